pc_unit_mc: RTL and testbench
=============================

Name: pc_unit_mc

Overview:
- Parametrised next-generation fetch PC generator: drives the I-cache enable and fetch address.
- Freezes fetch while a control-flow target depends on an unresolved register tag.
- Resolves that tag from any of NUM_CDB common-data-bus channels.
- Honours ROB redirects, and keeps a resolved-but-stalled target until the staller releases.

Parameters:
- ADDR_W, 32, width of pc, offsets, rob_npc, cdb_result.
- LOCK_W, 5, width of register lock tags; tag value 0 means "no lock".
- NUM_CDB, 2, number of CDB broadcast channels.
- RESET_PC, 0, fetch address after reset.
- INST_BYTES, 4, default sequential step.
- CDB_RELATIVE, 1, 1: CDB result is an offset added to pc; 0: CDB result is the absolute target.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ce  out  1  I-cache fetch enable.
- pc  out  ADDR_W  current fetch address.
- pc_locked  out  1  fetch frozen awaiting tag resolution (to staller).
- dec_valid  in  1  decoder info for instruction at pc is valid.
- dec_lock  in  LOCK_W  tag the target depends on; 0 = none.
- dec_offset  in  ADDR_W  signed pc increment when dec_lock==0.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_index  in  NUM_CDB*LOCK_W  packed tags; channel k at bits [k*LOCK_W +: LOCK_W].
- cdb_result  in  NUM_CDB*ADDR_W  packed results; channel k at bits [k*ADDR_W +: ADDR_W].
- rob_modify  in  1  ROB redirect (mispredict/exception).
- rob_npc  in  ADDR_W  redirect target.
- stall  in  1  staller hold.

Behaviour:
- Reset (async):
  - ce=0, pc=RESET_PC, pc_locked=0.
  - state=RUN, lock=0, pend=0.
- ce rises on the first clk edge after rst deasserts and stays 1.
- While ce=0, pc holds RESET_PC and no state update occurs.
- States:
  - RUN: sequencing.
  - LOCKED: waiting for a CDB match on lock.
  - RESOLVED: target known, stall held.
- pc_locked is a registered output, equal to (state != RUN).
- Priority each edge with ce=1 (highest first):
  - rob_modify: pc<=rob_npc; state<=RUN; lock<=0. Applies in any state, ignores stall.
  - RUN, stall=1: all state holds; dec_* and CDB ignored.
  - RUN, stall=0:
    - dec_valid=0: pc<=pc+INST_BYTES.
    - dec_valid=1, dec_lock=0: pc<=pc+dec_offset.
    - dec_valid=1, dec_lock!=0, same-cycle CDB match on dec_lock: apply target immediately, stay RUN.
    - dec_valid=1, dec_lock!=0, no match: lock<=dec_lock; state<=LOCKED; pc holds.
  - LOCKED, match: target computed.
    - stall=0: pc<=target; state<=RUN.
    - stall=1: pend<=target; state<=RESOLVED.
    - Matching is checked regardless of stall.
  - LOCKED, no match: pc and lock hold.
  - RESOLVED, stall=0: pc<=pend; state<=RUN; lock<=0.
  - RESOLVED, stall=1: hold; later CDB traffic ignored.
- CDB match:
  - Channel k matches if cdb_valid[k] && index_k==tag && tag!=0.
  - Multiple matches: lowest k wins.
  - Broadcasts of tag 0 never match.
- Target computation:
  - CDB_RELATIVE=1: pc + result.
  - CDB_RELATIVE=0: result.
- Arithmetic:
  - All adds are ADDR_W-bit modulo 2^ADDR_W; offsets are two's complement.
  - Wrap from top of address space to low addresses is legal, not flagged.
- rst asserted mid-LOCKED or mid-RESOLVED: immediate return to reset values; pending target discarded.

Decomposition:
- Shared package/defines:
  - NO_LOCK (=0).
  - State encoding: RUN=2'd0, LOCKED=2'd1, RESOLVED=2'd2.
  - Default ADDR_W/LOCK_W matching the existing instruction-address and lock-width defines.
- Sub-module pc_cdb_match:
  - Parametrised by NUM_CDB, LOCK_W, ADDR_W.
  - Inputs: tag, packed CDB buses.
  - Outputs: hit and selected result (lowest-index priority).
  - Purely combinational.
  - Instantiated twice: one for lock, one for dec_lock same-cycle bypass.

Test Plan:
- Reset release, dec_valid=0, stall=0 for 3 cycles -> ce=1 after 1 edge; pc 0→4→8→12; pc_locked=0.
- pc=0x20, dec_lock=3; 2 cycles later cdb ch1 valid, index=3, result=0x10 (CDB_RELATIVE=1) -> pc_locked=1 for 2 cycles, then pc=0x30, pc_locked=0.
- LOCKED on tag 5; ch0 and ch1 both broadcast tag 5 (results 0x8, 0x40) while stall=1 -> state RESOLVED, pc unchanged; drop stall -> pc=pc+0x8.
- LOCKED on tag 2; rob_modify=1, rob_npc=0x100, stall=1 -> next pc=0x100, pc_locked=0; later broadcast of tag 2 has no effect.
- pc=0xFFFFFFFC, dec_valid=1, dec_offset=8 -> pc=0x00000004; dec_offset=0xFFFFFFF0 from pc=0x10 -> pc=0x0.
- dec_lock=7 with same-cycle cdb ch0 index=7, result=0xC -> no lock, pc=pc+0xC, pc_locked stays 0; rst asserted while LOCKED -> pc=RESET_PC asynchronously.

Source files
------------

// File: rtl/pc_unit_mc_pkg.sv
// pc_unit_mc_pkg: shared types and constants for the fetch PC generator.
//   NO_LOCK     - tag value meaning "target does not depend on a register"
//   pc_state_e  - fetch sequencer states
//   PC_ADDR_W / PC_LOCK_W - default instruction-address and lock-tag widths
package pc_unit_mc_pkg;
  localparam int PC_ADDR_W = 32;
  localparam int PC_LOCK_W = 5;
  localparam int NO_LOCK = 0;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_RESOLVED = 2'd2
  } pc_state_e;
endpackage

// File: rtl/pc_unit_mc_cdb_match.sv
// pc_cdb_match: selects the lowest-index CDB channel broadcasting a given tag.
//   i_tag        - tag to look for; NO_LOCK never matches
//   i_cdb_valid  - per-channel valid
//   i_cdb_index  - packed channel tags
//   i_cdb_result - packed channel results
//   o_hit        - some channel matched
//   o_result     - result of the lowest matching channel ('0 when no hit)
module pc_cdb_match
  import pc_unit_mc_pkg::*;
#(
  parameter int NUM_CDB = 2,
  parameter int LOCK_W  = PC_LOCK_W,
  parameter int ADDR_W  = PC_ADDR_W
) (
  input  logic [LOCK_W-1:0]         i_tag,
  input  logic [NUM_CDB-1:0]        i_cdb_valid,
  input  logic [NUM_CDB*LOCK_W-1:0] i_cdb_index,
  input  logic [NUM_CDB*ADDR_W-1:0] i_cdb_result,
  output logic                      o_hit,
  output logic [ADDR_W-1:0]         o_result
);
  always_comb begin
    o_hit = 1'b0;
    o_result = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (!o_hit && i_tag != LOCK_W'(NO_LOCK) && i_cdb_valid[k] && i_cdb_index[k*LOCK_W +: LOCK_W] == i_tag) begin
        o_hit = 1'b1;
        o_result = i_cdb_result[k*ADDR_W +: ADDR_W];
      end
    end
  end
endmodule

// File: rtl/pc_unit_mc.sv
// pc_unit_mc: fetch PC generator with register-tag freeze and CDB resolution.
//   clk, rst            - clock, asynchronous active-high reset
//   ce, pc              - I-cache enable and fetch address
//   pc_locked           - fetch frozen until the pending target is applied
//   dec_valid/lock/offset - decoder info for the instruction at pc
//   cdb_valid/index/result - NUM_CDB packed broadcast channels
//   rob_modify, rob_npc - ROB redirect
//   stall               - staller hold
module pc_unit_mc
  import pc_unit_mc_pkg::*;
#(
  parameter int                ADDR_W       = PC_ADDR_W,
  parameter int                LOCK_W       = PC_LOCK_W,
  parameter int                NUM_CDB      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                INST_BYTES   = 4,
  parameter bit                CDB_RELATIVE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ce,
  output logic [ADDR_W-1:0]         pc,
  output logic                      pc_locked,
  input  logic                      dec_valid,
  input  logic [LOCK_W-1:0]         dec_lock,
  input  logic [ADDR_W-1:0]         dec_offset,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*LOCK_W-1:0] cdb_index,
  input  logic [NUM_CDB*ADDR_W-1:0] cdb_result,
  input  logic                      rob_modify,
  input  logic [ADDR_W-1:0]         rob_npc,
  input  logic                      stall
);
  pc_state_e         r_state, w_state_n;
  logic              r_ce, r_locked;
  logic [ADDR_W-1:0] r_pc, r_pend, w_pc_n, w_pend_n;
  logic [LOCK_W-1:0] r_lock, w_lock_n;
  logic              w_lock_hit, w_dec_hit;
  logic [ADDR_W-1:0] w_lock_res, w_dec_res, w_lock_tgt, w_dec_tgt;

  pc_cdb_match #(.NUM_CDB(NUM_CDB), .LOCK_W(LOCK_W), .ADDR_W(ADDR_W)) u_lock_match (
    .i_tag(r_lock), .i_cdb_valid(cdb_valid), .i_cdb_index(cdb_index),
    .i_cdb_result(cdb_result), .o_hit(w_lock_hit), .o_result(w_lock_res)
  );

  // Same-cycle bypass: a decoder tag already on the CDB never freezes fetch.
  pc_cdb_match #(.NUM_CDB(NUM_CDB), .LOCK_W(LOCK_W), .ADDR_W(ADDR_W)) u_dec_match (
    .i_tag(dec_lock), .i_cdb_valid(cdb_valid), .i_cdb_index(cdb_index),
    .i_cdb_result(cdb_result), .o_hit(w_dec_hit), .o_result(w_dec_res)
  );

  assign w_lock_tgt = CDB_RELATIVE ? r_pc + w_lock_res : w_lock_res;
  assign w_dec_tgt  = CDB_RELATIVE ? r_pc + w_dec_res : w_dec_res;

  always_comb begin
    w_state_n = r_state;
    w_pc_n = r_pc;
    w_lock_n = r_lock;
    w_pend_n = r_pend;
    if (rob_modify) begin
      w_pc_n = rob_npc;
      w_state_n = ST_RUN;
      w_lock_n = LOCK_W'(NO_LOCK);
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!stall) begin
            if (!dec_valid) w_pc_n = r_pc + ADDR_W'(INST_BYTES);
            else if (dec_lock == LOCK_W'(NO_LOCK)) w_pc_n = r_pc + dec_offset;
            else if (w_dec_hit) w_pc_n = w_dec_tgt;
            else begin
              w_lock_n = dec_lock;
              w_state_n = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (w_lock_hit) begin
            w_lock_n = LOCK_W'(NO_LOCK);
            w_state_n = stall ? ST_RESOLVED : ST_RUN;
            w_pend_n = stall ? w_lock_tgt : r_pend;
            w_pc_n = stall ? r_pc : w_lock_tgt;
          end
        end
        ST_RESOLVED: begin
          if (!stall) begin
            w_pc_n = r_pend;
            w_state_n = ST_RUN;
            w_lock_n = LOCK_W'(NO_LOCK);
          end
        end
        default: w_state_n = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce <= 1'b0;
      r_pc <= RESET_PC;
      r_state <= ST_RUN;
      r_lock <= LOCK_W'(NO_LOCK);
      r_pend <= '0;
      r_locked <= 1'b0;
    end else if (!r_ce) begin
      r_ce <= 1'b1;
    end else begin
      r_pc <= w_pc_n;
      r_state <= w_state_n;
      r_lock <= w_lock_n;
      r_pend <= w_pend_n;
      r_locked <= w_state_n != ST_RUN;
    end
  end

  assign ce = r_ce;
  assign pc = r_pc;
  assign pc_locked = r_locked;
endmodule

// File: tb/tb_pc_unit_mc.sv
module tb_pc_unit_mc;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ce, pc_locked;
  logic [31:0] pc;
  logic        dv, rob, stall;
  logic [4:0]  dl;
  logic [31:0] doff, npc;
  logic [1:0]  cv;
  logic [9:0]  ci;
  logic [63:0] cr;
  int          total = 0, bad = 0;
  bit          m_ce, m_wait, m_have;
  logic [31:0] m_pc, m_tgt;
  logic [4:0]  m_tag;

  pc_unit_mc #(.ADDR_W(32), .LOCK_W(5), .NUM_CDB(2), .RESET_PC(32'h0), .INST_BYTES(4), .CDB_RELATIVE(1'b1)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .pc_locked(pc_locked),
    .dec_valid(dv), .dec_lock(dl), .dec_offset(doff),
    .cdb_valid(cv), .cdb_index(ci), .cdb_result(cr),
    .rob_modify(rob), .rob_npc(npc), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic void lookup(input logic [4:0] tag, output bit hit, output logic [31:0] res);
    logic [31:0] q[$];
    if (tag != 0) begin
      if (cv[0] && ci[4:0] == tag) q.push_back(cr[31:0]);
      if (cv[1] && ci[9:5] == tag) q.push_back(cr[63:32]);
    end
    hit = q.size() > 0;
    res = hit ? q[0] : 32'h0;
  endfunction

  task automatic quiet();
    dv = 0; dl = 0; doff = 0; cv = 0; ci = 0; cr = 0; rob = 0; npc = 0; stall = 0;
  endtask

  task automatic model_reset();
    m_ce = 0; m_pc = 0; m_wait = 0; m_have = 0; m_tgt = 0; m_tag = 0;
  endtask

  task automatic cdb(input bit v0, input logic [4:0] i0, input logic [31:0] r0,
                     input bit v1, input logic [4:0] i1, input logic [31:0] r1);
    cv = {v1, v0}; ci = {i1, i0}; cr = {r1, r0};
  endtask

  task automatic step();
    bit h;
    logic [31:0] r;
    if (!m_ce) m_ce = 1;
    else if (rob) begin m_pc = npc; m_wait = 0; m_have = 0; end
    else if (m_have) begin
      if (!stall) begin m_pc = m_tgt; m_have = 0; end
    end else if (m_wait) begin
      lookup(m_tag, h, r);
      if (h) begin
        m_wait = 0;
        if (stall) begin m_have = 1; m_tgt = m_pc + r; end
        else m_pc = m_pc + r;
      end
    end else if (!stall) begin
      if (!dv) m_pc = m_pc + 4;
      else if (dl == 0) m_pc = m_pc + doff;
      else begin
        lookup(dl, h, r);
        if (h) m_pc = m_pc + r;
        else begin m_wait = 1; m_tag = dl; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    quiet(); rob = 1; npc = a; step(); quiet();
  endtask

  task automatic test_reset();
    quiet();
    model_reset();
    #12;
    total++;
    if ({ce, pc_locked, pc} !== 34'h0) begin bad++; $display("FAIL reset_vals got ce=%b lk=%b pc=%h want 0 0 0", ce, pc_locked, pc); end
    @(negedge clk); rst = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if ({ce, pc_locked, pc} !== {m_ce, m_wait | m_have, m_pc}) begin bad++; $display("FAIL seq_%0d got ce=%b lk=%b pc=%h want %b %b %h", i, ce, pc_locked, pc, m_ce, m_wait | m_have, m_pc); end
    end
    total++;
    if (pc !== 32'd12 || ce !== 1'b1) begin bad++; $display("FAIL seq_end got pc=%h ce=%b want 0000000c 1", pc, ce); end
  endtask

  task automatic test_lock_resolve();
    redirect(32'h20);
    dv = 1; dl = 3; step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b1, 32'h20}) begin bad++; $display("FAIL lock_enter got lk=%b pc=%h want 1 00000020", pc_locked, pc); end
    step();
    total++;
    if ({pc_locked, pc} !== {1'b1, 32'h20}) begin bad++; $display("FAIL lock_hold got lk=%b pc=%h want 1 00000020", pc_locked, pc); end
    cdb(0, 0, 0, 1, 3, 32'h10); step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b0, 32'h30}) begin bad++; $display("FAIL lock_resolve got lk=%b pc=%h want 0 00000030", pc_locked, pc); end
  endtask

  task automatic test_stall_resolved();
    redirect(32'h40);
    dv = 1; dl = 5; step(); quiet();
    stall = 1; cdb(1, 5, 32'h8, 1, 5, 32'h40); step();
    total++;
    if ({pc_locked, pc} !== {1'b1, 32'h40}) begin bad++; $display("FAIL resolved_hold got lk=%b pc=%h want 1 00000040", pc_locked, pc); end
    cdb(1, 5, 32'h100, 0, 0, 0); step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b1, 32'h40}) begin bad++; $display("FAIL resolved_ignore got lk=%b pc=%h want 1 00000040", pc_locked, pc); end
    step();
    total++;
    if ({pc_locked, pc} !== {1'b0, 32'h48}) begin bad++; $display("FAIL resolved_release got lk=%b pc=%h want 0 00000048", pc_locked, pc); end
  endtask

  task automatic test_rob_redirect();
    dv = 1; dl = 2; step(); quiet();
    rob = 1; npc = 32'h100; stall = 1; step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b0, 32'h100}) begin bad++; $display("FAIL rob_redirect got lk=%b pc=%h want 0 00000100", pc_locked, pc); end
    cdb(1, 2, 32'h50, 0, 0, 0); step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b0, 32'h104}) begin bad++; $display("FAIL rob_stale_cdb got lk=%b pc=%h want 0 00000104", pc_locked, pc); end
  endtask

  task automatic test_wrap();
    redirect(32'hFFFF_FFFC);
    dv = 1; doff = 32'h8; step(); quiet();
    total++;
    if (pc !== 32'h4) begin bad++; $display("FAIL wrap_up got pc=%h want 00000004", pc); end
    redirect(32'h10);
    dv = 1; doff = 32'hFFFF_FFF0; step(); quiet();
    total++;
    if (pc !== 32'h0) begin bad++; $display("FAIL wrap_neg got pc=%h want 00000000", pc); end
  endtask

  task automatic test_bypass_and_reset();
    redirect(32'h200);
    dv = 1; dl = 7; cdb(1, 7, 32'hC, 0, 0, 0); step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b0, 32'h20C}) begin bad++; $display("FAIL bypass got lk=%b pc=%h want 0 0000020c", pc_locked, pc); end
    dv = 1; dl = 6; step(); quiet();
    cdb(1, 0, 32'h4, 1, 0, 32'h8); step(); quiet();
    total++;
    if ({pc_locked, pc} !== {1'b1, 32'h20C}) begin bad++; $display("FAIL tag0_nomatch got lk=%b pc=%h want 1 0000020c", pc_locked, pc); end
    #2 rst = 1;
    #1;
    total++;
    if ({ce, pc_locked, pc} !== 34'h0) begin bad++; $display("FAIL async_reset_locked got ce=%b lk=%b pc=%h want 0 0 0", ce, pc_locked, pc); end
    model_reset();
    @(negedge clk); rst = 0;
    step();
    redirect(32'h80);
    dv = 1; dl = 1; step(); quiet();
    stall = 1; cdb(0, 0, 0, 1, 1, 32'h1000); step(); quiet();
    #2 rst = 1;
    #1;
    total++;
    if ({ce, pc_locked, pc} !== 34'h0) begin bad++; $display("FAIL async_reset_resolved got ce=%b lk=%b pc=%h want 0 0 0", ce, pc_locked, pc); end
    model_reset();
    @(negedge clk); rst = 0;
    step(); step(); step();
    total++;
    if ({ce, pc_locked, pc} !== {1'b1, 1'b0, 32'h8}) begin bad++; $display("FAIL pend_discarded got ce=%b lk=%b pc=%h want 1 0 00000008", ce, pc_locked, pc); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rob = ($urandom_range(15) == 0);
      npc = $urandom & 32'hFFFF_FFFC;
      stall = ($urandom_range(2) == 0);
      dv = $urandom_range(1);
      dl = ($urandom_range(1) == 0) ? 5'd0 : 5'($urandom_range(3));
      doff = $urandom_range(1) ? $urandom : 32'($signed(5'($urandom_range(31))) * 4);
      cdb($urandom_range(1), 5'($urandom_range(3)), $urandom, $urandom_range(1), 5'($urandom_range(3)), $urandom);
      step();
      total++;
      if ({ce, pc_locked, pc} !== {m_ce, m_wait | m_have, m_pc}) begin bad++; $display("FAIL rand_%0d got ce=%b lk=%b pc=%h want %b %b %h", i, ce, pc_locked, pc, m_ce, m_wait | m_have, m_pc); end
    end
    quiet();
  endtask

  initial begin
    test_reset();
    test_lock_resolve();
    test_stall_resolved();
    test_rob_redirect();
    test_wrap();
    test_bypass_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
